mem_access_ctrl: RTL

Initiator-side controller that drives the byte-wide data RAM on behalf of the pipeline MEM stage. It accepts one load/store request at a time over a valid/ready handshake and sequences 1, 2 or 4 single-byte RAM transfers, big-endian. It assembles and sign- or zero-extends load data, then returns a single-cycle response. It also rejects misaligned, out-of-range and illegal-size requests without touching the RAM.

---
 rtl/mem_access_pkg.sv | 24 ++
 rtl/mem_access_ctrl_if.sv | 36 +++
 rtl/mem_load_extend.sv | 20 ++
 rtl/mem_access_ctrl.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared encodings for the MEM-stage byte-RAM access controller.
package mem_access_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Illegal sizes report one byte; they are rejected before the count matters.
  function automatic logic [2:0] size_nbytes(input logic [1:0] size);
    case (size)
      SZ_HALF: size_nbytes = 3'd2;
      SZ_WORD: size_nbytes = 3'd4;
      default: size_nbytes = 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request/response handshake plus byte-RAM bus between the MEM stage, controller and RAM.
interface mem_access_ctrl_if #(
  parameter int ADDR_WIDTH = 32
);

  logic                  ReqValid;
  logic                  ReqReady;
  logic                  ReqWrite;
  logic [1:0]            ReqSize;
  logic                  ReqSigned;
  logic [ADDR_WIDTH-1:0] ReqAddress;
  logic [31:0]           ReqWData;
  logic                  RspValid;
  logic [31:0]           RspRData;
  logic                  RspError;
  logic                  Enable;
  logic                  ReadWrite;
  logic [ADDR_WIDTH-1:0] Address;
  logic [7:0]            DataIn;
  logic [7:0]            DataOut;

  // Controller side: serves requests, drives the RAM.
  modport slave (
    input  ReqValid, ReqWrite, ReqSize, ReqSigned, ReqAddress, ReqWData, DataOut,
    output ReqReady, RspValid, RspRData, RspError,
    output Enable, ReadWrite, Address, DataIn
  );

  // Requester and RAM side.
  modport master (
    output ReqValid, ReqWrite, ReqSize, ReqSigned, ReqAddress, ReqWData, DataOut,
    input  ReqReady, RspValid, RspRData, RspError,
    input  Enable, ReadWrite, Address, DataIn
  );

endinterface

// File: rtl/mem_load_extend.sv
// Sign/zero extension of big-endian assembled load data to 32 bits.
module mem_load_extend
  import mem_access_pkg::*;
(
  input  logic [31:0] asm_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  output logic [31:0] data_o
);

  always_comb begin
    data_o = asm_i;
    case (size_i)
      SZ_BYTE: data_o = {{24{signed_i & asm_i[7]}}, asm_i[7:0]};
      SZ_HALF: data_o = {{16{signed_i & asm_i[15]}}, asm_i[15:0]};
      default: data_o = asm_i;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Sequences 1/2/4 single-byte RAM transfers (big-endian) per load/store request,
// rejecting misaligned, out-of-range and illegal-size requests without a RAM cycle.
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int RAM_DEPTH  = 256,
  parameter int ADDR_WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset_n,
  mem_access_ctrl_if.slave bus
);

  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(RAM_DEPTH);

  state_e                state_q, state_d;
  logic [1:0]            idx_q, idx_d;
  logic                  write_q, write_d;
  logic [1:0]            size_q, size_d;
  logic                  sgn_q, sgn_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           asm_q, asm_d;
  logic                  err_q, err_d;

  logic                  req_ready;
  logic                  rsp_valid;
  logic [31:0]           rsp_rdata;
  logic                  rsp_error;
  logic                  ram_en;
  logic                  ram_rw;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [7:0]            ram_wdata;

  logic [2:0]            req_nbytes;
  logic [ADDR_WIDTH:0]   req_end;
  logic                  req_err;
  logic [1:0]            last_idx;
  logic [1:0]            store_sel;
  logic [31:0]           ext_data;

  // Request checks evaluated on the live request while IDLE; one extra bit keeps
  // the end-address sum from wrapping near the top of the address space.
  always_comb begin
    req_nbytes = size_nbytes(bus.ReqSize);
    req_end    = {1'b0, bus.ReqAddress} + {{(ADDR_WIDTH-2){1'b0}}, req_nbytes};
    req_err    = (bus.ReqSize == SZ_ILL)
               | ((bus.ReqSize == SZ_HALF) & bus.ReqAddress[0])
               | ((bus.ReqSize == SZ_WORD) & (|bus.ReqAddress[1:0]))
               | (req_end > DEPTH_LIM);
  end

  assign last_idx  = 2'(size_nbytes(size_q) - 3'd1);
  // Most significant byte goes out first, to the lowest address.
  assign store_sel = last_idx - idx_q;

  mem_load_extend u_extend (
    .asm_i    (asm_q),
    .size_i   (size_q),
    .signed_i (sgn_q),
    .data_o   (ext_data)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
      idx_q   <= 2'd0;
      write_q <= 1'b0;
      size_q  <= SZ_BYTE;
      sgn_q   <= 1'b0;
      base_q  <= '0;
      wdata_q <= 32'd0;
      asm_q   <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      write_q <= write_d;
      size_q  <= size_d;
      sgn_q   <= sgn_d;
      base_q  <= base_d;
      wdata_q <= wdata_d;
      asm_q   <= asm_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    write_d   = write_q;
    size_d    = size_q;
    sgn_d     = sgn_q;
    base_d    = base_q;
    wdata_d   = wdata_q;
    asm_d     = asm_q;
    err_d     = err_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_rdata = 32'd0;
    rsp_error = 1'b0;
    ram_en    = 1'b0;
    ram_rw    = 1'b0;
    ram_addr  = '0;
    ram_wdata = 8'd0;

    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (bus.ReqValid) begin
          write_d = bus.ReqWrite;
          size_d  = bus.ReqSize;
          sgn_d   = bus.ReqSigned;
          base_d  = bus.ReqAddress;
          wdata_d = bus.ReqWData;
          asm_d   = 32'd0;
          idx_d   = 2'd0;
          err_d   = req_err;
          state_d = req_err ? ST_RESP : ST_XFER;
        end
      end

      ST_XFER: begin
        ram_en   = 1'b1;
        ram_rw   = write_q;
        ram_addr = base_q + ADDR_WIDTH'(idx_q);
        if (write_q) begin
          ram_wdata = wdata_q[{store_sel, 3'b000} +: 8];
        end else begin
          asm_d = {asm_q[23:0], bus.DataOut};
        end
        idx_d = idx_q + 2'd1;
        if (idx_q == last_idx) begin
          state_d = ST_RESP;
        end
      end

      ST_RESP: begin
        rsp_valid = 1'b1;
        rsp_error = err_q;
        if (!err_q && !write_q) begin
          rsp_rdata = ext_data;
        end
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.ReqReady  = req_ready;
  assign bus.RspValid  = rsp_valid;
  assign bus.RspRData  = rsp_rdata;
  assign bus.RspError  = rsp_error;
  assign bus.Enable    = ram_en;
  assign bus.ReadWrite = ram_rw;
  assign bus.Address   = ram_addr;
  assign bus.DataIn    = ram_wdata;

endmodule
